// File: rtl/ysyx_23060208_uart_tx_pkg.sv
// Shared constants for the UART TX peripheral: register offsets,
// AXI response codes and the transmitter FSM state encoding.
package ysyx_23060208_uart_tx_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/ysyx_23060208_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop may coincide,
// including a push while full when a pop happens in the same cycle.
// Ports: clk, rst (async, active-low), i_push/i_data, i_pop,
//        o_data (head entry), o_full, o_empty, o_count.
module ysyx_23060208_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_empty = (r_wr == r_rd);
    // Same slot but different lap: the writer is a full lap ahead.
    assign o_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) &&
                     (r_wr[AW] != r_rd[AW]);
    assign o_count = r_wr - r_rd;

endmodule

// File: rtl/ysyx_23060208_uart_tx.sv
// AXI4-Lite UART transmitter: writes to TXDATA queue bytes, a baud-timed
// shifter sends them as 8N1 frames; STATUS reports FIFO/shifter state.
// Ports: clk, rst (async, active-low), AXI4-Lite AW/W/B/AR/R channels
//        (uart_*), uart_tx serial line (idles high).
// Macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module ysyx_23060208_uart_tx
    import ysyx_23060208_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] uart_awaddr,
    input  logic                  uart_awvalid,
    output logic                  uart_awready,
    input  logic [DATA_WIDTH-1:0] uart_wdata,
    input  logic [2:0]            uart_wstrb,
    input  logic                  uart_wvalid,
    output logic                  uart_wready,
    output logic [1:0]            uart_bresp,
    output logic                  uart_bvalid,
    input  logic                  uart_bready,
    input  logic [DATA_WIDTH-1:0] uart_araddr,
    input  logic                  uart_arvalid,
    output logic                  uart_arready,
    output logic [DATA_WIDTH-1:0] uart_rdata,
    output logic [1:0]            uart_rresp,
    output logic                  uart_rvalid,
    input  logic                  uart_rready,
    output logic                  uart_tx
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LD = BW'(BAUD_DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_BIT = 1'b1;
`else
    localparam logic PAR_BIT = 1'b0;
`endif

    // Write channel
    logic       r_aw_vld;
    logic       r_w_vld;
    logic [1:0] r_awoff;
    logic [7:0] r_wbyte;
    logic [2:0] r_wstrb;
    logic       r_bvalid;
    logic [1:0] r_bresp;

    // Read channel
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Transmitter
    tx_state_e      r_state;
    tx_state_e      w_state_nxt;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           w_tick;
    logic           w_pop;
    logic           w_rot;
    logic           w_tx;

    // FIFO
    logic           w_push;
    logic [7:0]     w_fifo_dout;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_cnt;

    logic           w_wr_fire;
    logic           w_wr_req;
    logic [1:0]     w_bresp;
    logic [7:0]     w_stat;
    logic [1:0]     w_ar_off;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]     w_rd_resp;
    logic           w_unused;

    assign w_unused = ^{uart_awaddr[DATA_WIDTH-1:4],
                        uart_awaddr[1:0],
                        uart_araddr[DATA_WIDTH-1:4],
                        uart_araddr[1:0],
                        uart_wdata[DATA_WIDTH-1:8]};

    assign uart_awready = !r_aw_vld && !r_bvalid;
    assign uart_wready  = !r_w_vld && !r_bvalid;
    assign uart_arready = !r_rvalid;
    assign uart_bvalid  = r_bvalid;
    assign uart_bresp   = r_bresp;
    assign uart_rvalid  = r_rvalid;
    assign uart_rresp   = r_rresp;
    assign uart_rdata   = r_rdata;
    assign uart_tx      = w_tx;

    ysyx_23060208_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_wbyte),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    // ---------------- write path ----------------
    // One attempt per latched AW+W pair; bvalid blocks re-firing.
    assign w_wr_fire = r_aw_vld && r_w_vld && !r_bvalid;
    assign w_wr_req  = w_wr_fire && (|r_wstrb) &&
                       (r_awoff == UART_TXDATA[3:2]);
    // A pop in the same cycle frees the slot this push takes.
    assign w_push    = w_wr_req && (!w_full || w_pop);

    always_comb begin
        w_bresp = RESP_OKAY;
        if (r_awoff[1]) begin
            w_bresp = RESP_DECERR;
        end else if (w_wr_req && !w_push) begin
            w_bresp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_vld <= 1'b0;
            r_w_vld  <= 1'b0;
            r_awoff  <= '0;
            r_wbyte  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (uart_awvalid && uart_awready) begin
                r_aw_vld <= 1'b1;
                r_awoff  <= uart_awaddr[3:2];
            end
            if (uart_wvalid && uart_wready) begin
                r_w_vld <= 1'b1;
                r_wbyte <= uart_wdata[7:0];
                r_wstrb <= uart_wstrb;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_bresp;
            end else if (r_bvalid && uart_bready) begin
                r_bvalid <= 1'b0;
                r_aw_vld <= 1'b0;
                r_w_vld  <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    assign w_stat   = {4'(w_cnt), PAR_BIT,
                       (r_state != S_IDLE), w_empty, w_full};
    assign w_ar_off = uart_araddr[3:2];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        unique case (1'b1)
            (w_ar_off == UART_TXDATA[3:2]): begin
                w_rd_data = '0;
            end
            (w_ar_off == UART_STATUS[3:2]): begin
                w_rd_data = DATA_WIDTH'(w_stat);
            end
            default: begin
                w_rd_resp = RESP_DECERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (uart_arvalid && uart_arready) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && uart_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    assign w_tick = (r_baud == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rot       = 1'b0;
        w_tx        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tick) begin
                    w_rot = 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                // Eight rotations restore the byte, so XOR is still valid.
                w_tx = ^r_shift;
                if (w_tick) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= BAUD_LD;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state || w_tick ||
                r_state == S_IDLE) begin
                r_baud <= BAUD_LD;
            end else begin
                r_baud <= r_baud - BW'(1);
            end
            if (w_pop) begin
                r_shift <= w_fifo_dout;
                r_bit   <= '0;
            end else if (w_rot) begin
                // Rotate rather than shift so the byte survives the frame.
                r_shift <= {r_shift[0], r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_uart_tx.sv
// Self-checking bench for ysyx_23060208_uart_tx: table vectors, directed
// sequences and randomized writes against a frame-decoding line model.
module tb_ysyx_23060208_uart_tx;

    localparam int DW = 32;
    localparam int BD = 4;
    localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PB = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif
    localparam int FRAME = NB * BD;
    localparam logic [31:0] ST_IDLE = 32'h2 | PB;

    logic          clk;
    logic          rst;
    logic [DW-1:0] uart_awaddr;
    logic          uart_awvalid;
    logic          uart_awready;
    logic [DW-1:0] uart_wdata;
    logic [2:0]    uart_wstrb;
    logic          uart_wvalid;
    logic          uart_wready;
    logic [1:0]    uart_bresp;
    logic          uart_bvalid;
    logic          uart_bready;
    logic [DW-1:0] uart_araddr;
    logic          uart_arvalid;
    logic          uart_arready;
    logic [DW-1:0] uart_rdata;
    logic [1:0]    uart_rresp;
    logic          uart_rvalid;
    logic          uart_rready;
    logic          uart_tx;

    int n_tests;
    int n_fail;
    int cyc;
    logic [7:0] exp_q[$];
    int starts[$];

    ysyx_23060208_uart_tx #(
        .DATA_WIDTH (DW),
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_awaddr  (uart_awaddr),
        .uart_awvalid (uart_awvalid),
        .uart_awready (uart_awready),
        .uart_wdata   (uart_wdata),
        .uart_wstrb   (uart_wstrb),
        .uart_wvalid  (uart_wvalid),
        .uart_wready  (uart_wready),
        .uart_bresp   (uart_bresp),
        .uart_bvalid  (uart_bvalid),
        .uart_bready  (uart_bready),
        .uart_araddr  (uart_araddr),
        .uart_arvalid (uart_arvalid),
        .uart_arready (uart_arready),
        .uart_rdata   (uart_rdata),
        .uart_rresp   (uart_rresp),
        .uart_rvalid  (uart_rvalid),
        .uart_rready  (uart_rready),
        .uart_tx      (uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Line model: decode every frame from the start bit, demand each
    // level be held exactly BD cycles, and match bytes in write order.
    initial begin : mon
        logic [7:0] b;
        logic ok;
        logic ab;
        logic v;
        int t0;
        forever begin
            @(negedge clk);
            if (rst && uart_tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                ab = 1'b0;
                b  = 8'h0;
                v  = 1'b0;
                for (int k = 0; k < NB && !ab; k++) begin
                    for (int c = 0; c < BD && !ab; c++) begin
                        if (!(k == 0 && c == 0)) @(negedge clk);
                        if (!rst) ab = 1'b1;
                        else if (c == 0) v = uart_tx;
                        else if (uart_tx !== v) ok = 1'b0;
                    end
                    if (!ab) begin
                        if (k == 0 && v !== 1'b0) ok = 1'b0;
                        if (k >= 1 && k <= 8) b[k-1] = v;
                        if (k == NB - 1 && v !== 1'b1) ok = 1'b0;
`ifdef UART_TX_PARITY_EN
                        if (k == 9 && v !== ^b) ok = 1'b0;
`endif
                    end
                end
                if (!ab) begin
                    starts.push_back(t0);
                    check("frame_timing", {31'b0, ok}, 32'h1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %h, want none", b);
                    end else begin
                        check("frame_byte", {24'b0, b},
                              {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_sig(input string nm, ref logic s);
        int t;
        t = 0;
        while (s !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check(nm, {31'b0, s}, 32'h1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] s, input int daw,
                             input int dw, input int db,
                             output logic [1:0] resp, output int lat,
                             output logic awr_at_w);
        int ta;
        int tw;
        int tb;
        ta = 0;
        tw = 0;
        awr_at_w = 1'b1;
        fork
            begin
                repeat (daw) @(negedge clk);
                uart_awaddr  = a;
                uart_awvalid = 1'b1;
                wait_sig("aw_ready", uart_awready);
                @(negedge clk);
                ta = cyc;
                uart_awvalid = 1'b0;
            end
            begin
                repeat (dw) @(negedge clk);
                awr_at_w    = uart_awready;
                uart_wdata  = d;
                uart_wstrb  = s;
                uart_wvalid = 1'b1;
                wait_sig("w_ready", uart_wready);
                @(negedge clk);
                tw = cyc;
                uart_wvalid = 1'b0;
            end
        join
        wait_sig("b_valid", uart_bvalid);
        tb   = cyc;
        resp = uart_bresp;
        lat  = tb - ((ta > tw) ? ta : tw);
        if (db > 0) begin
            repeat (db) @(negedge clk);
            check("b_hold", {31'b0, uart_bvalid}, 32'h1);
        end
        uart_bready = 1'b1;
        @(negedge clk);
        uart_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a,
                            output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        int ta;
        uart_araddr  = a;
        uart_arvalid = 1'b1;
        wait_sig("ar_ready", uart_arready);
        @(negedge clk);
        uart_arvalid = 1'b0;
        ta = cyc;
        wait_sig("r_valid", uart_rvalid);
        lat  = cyc - ta;
        d    = uart_rdata;
        resp = uart_rresp;
        uart_rready = 1'b1;
        @(negedge clk);
        uart_rready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  strb;
        logic [1:0]  eresp;
        logic [31:0] edata;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic        awr;
        int          lat;
        int          n;
        logic [7:0]  bt;
        logic [31:0] off;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        uart_awaddr = '0; uart_awvalid = 1'b0;
        uart_wdata = '0;  uart_wstrb = '0; uart_wvalid = 1'b0;
        uart_bready = 1'b0;
        uart_araddr = '0; uart_arvalid = 1'b0;
        uart_rready = 1'b0;

        vt[0] = '{1'b0, 32'h0,   32'h0,  3'd0, 2'b00, 32'h0};
        vt[1] = '{1'b0, 32'h4,   32'h0,  3'd0, 2'b00, ST_IDLE};
        vt[2] = '{1'b0, 32'h8,   32'h0,  3'd0, 2'b11, 32'h0};
        vt[3] = '{1'b0, 32'hC,   32'h0,  3'd0, 2'b11, 32'h0};
        vt[4] = '{1'b1, 32'h4,   32'hFF, 3'd7, 2'b00, 32'h0};
        vt[5] = '{1'b1, 32'h8,   32'h31, 3'd1, 2'b11, 32'h0};
        vt[6] = '{1'b1, 32'hC,   32'h32, 3'd1, 2'b11, 32'h0};
        vt[7] = '{1'b1, 32'h0,   32'h33, 3'd0, 2'b00, 32'h0};
        vt[8] = '{1'b0, 32'h104, 32'h0,  3'd0, 2'b00, ST_IDLE};
        vt[9] = '{1'b0, 32'h10,  32'h0,  3'd0, 2'b00, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_bvalid", {31'b0, uart_bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, uart_rvalid}, 32'h0);
        check("rst_bresp", {30'b0, uart_bresp}, 32'h0);
        check("rst_rresp", {30'b0, uart_rresp}, 32'h0);
        check("rst_rdata", uart_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready",
              {29'b0, uart_awready, uart_wready, uart_arready}, 32'h7);

        // Reset in the middle of a frame
        exp_q.push_back(8'h3C);
        axi_write(32'h0, 32'h3C, 3'd1, 0, 0, 0, r, lat, awr);
        check("mid_wr_resp", {30'b0, r}, 32'h0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", {31'b0, uart_tx}, 32'h1);
        check("mid_rst_bv", {31'b0, uart_bvalid}, 32'h0);
        check("mid_rst_rv", {31'b0, uart_rvalid}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready",
              {29'b0, uart_awready, uart_wready, uart_arready}, 32'h7);
        axi_read(32'h4, d, r, lat);
        check("mid_rst_status", d, ST_IDLE);
        check("r_latency", lat, 0);
        repeat (FRAME) @(negedge clk);

        // Single byte 0x55
        exp_q.push_back(8'h55);
        axi_write(32'h0, 32'h55, 3'd1, 0, 0, 0, r, lat, awr);
        check("w55_resp", {30'b0, r}, 32'h0);
        check("w55_blat", lat, 1);
        repeat (FRAME + 20) @(negedge clk);
        check("w55_drained", exp_q.size(), 0);

        // Decode table while idle
        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb,
                          0, 0, 0, r, lat, awr);
                check($sformatf("vec%0d_bresp", i), {30'b0, r},
                      {30'b0, vt[i].eresp});
            end else begin
                axi_read(vt[i].addr, d, r, lat);
                check($sformatf("vec%0d_rresp", i), {30'b0, r},
                      {30'b0, vt[i].eresp});
                check($sformatf("vec%0d_rdata", i), d, vt[i].edata);
            end
        end
        repeat (FRAME) @(negedge clk);

        // Six back-to-back writes: one shifting, four queued, one dropped
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'h41 + 8'(i));
            axi_write(32'h0, 32'h41 + i, 3'd1, 0, 0, 0, r, lat, awr);
            check($sformatf("burst%0d_resp", i), {30'b0, r},
                  (i < 5) ? 32'h0 : 32'h2);
        end
        repeat (5 * FRAME + 20) @(negedge clk);
        check("burst_drained", exp_q.size(), 0);
        check("burst_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) begin
            check("burst_gap", starts[i] - starts[i-1], FRAME);
        end

        // STATUS while busy with two queued
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h10 * 8'(i + 1));
            axi_write(32'h0, 32'h10 * (i + 1), 3'd1, 0, 0, 0,
                      r, lat, awr);
        end
        axi_read(32'h4, d, r, lat);
        check("busy_status", d, 32'h24 | PB);
        repeat (3 * FRAME + 20) @(negedge clk);
        axi_read(32'h4, d, r, lat);
        check("drain_status", d, ST_IDLE);

        // Decode errors and AW ahead of W
        axi_write(32'h8, 32'h99, 3'd1, 0, 0, 0, r, lat, awr);
        check("dec_wr_resp", {30'b0, r}, 32'h3);
        axi_read(32'hC, d, r, lat);
        check("dec_rd_resp", {30'b0, r}, 32'h3);
        check("dec_rd_data", d, 32'h0);
        exp_q.push_back(8'hA5);
        axi_write(32'h0, 32'hA5, 3'd1, 0, 3, 2, r, lat, awr);
        check("skew_resp", {30'b0, r}, 32'h0);
        check("skew_blat", lat, 1);
        check("skew_aw_blocked", {31'b0, awr}, 32'h0);
        check("skew_single_b", {31'b0, uart_bvalid}, 32'h0);
        repeat (FRAME + 20) @(negedge clk);
        check("skew_drained", exp_q.size(), 0);

        // 0x07: odd weight, parity bit 1 when enabled
        starts.delete();
        exp_q.push_back(8'h07);
        axi_write(32'h0, 32'h07, 3'd1, 0, 0, 0, r, lat, awr);
        repeat (FRAME + 20) @(negedge clk);
        check("b07_frames", starts.size(), 1);
        check("b07_drained", exp_q.size(), 0);

        // Randomized bursts from idle
        for (int rnd = 0; rnd < 8; rnd++) begin
            n = $urandom_range(1, FD + 1);
            for (int j = 0; j < n; j++) begin
                bt = 8'($urandom);
                exp_q.push_back(bt);
                axi_write(32'h0, {24'($urandom), bt},
                          3'($urandom_range(1, 7)),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), r, lat, awr);
                check("rnd_wr_resp", {30'b0, r}, 32'h0);
                check("rnd_wr_blat", lat, 1);
                if ($urandom_range(0, 1) == 1) begin
                    off = 32'($urandom_range(0, 3)) * 4;
                    if (off != 32'h4) begin
                        axi_read(off, d, r, lat);
                        check("rnd_rd_resp", {30'b0, r},
                              (off >= 32'h8) ? 32'h3 : 32'h0);
                        check("rnd_rd_data", d, 32'h0);
                    end
                end
            end
            repeat ((n + 1) * FRAME + 20) @(negedge clk);
            check("rnd_drained", exp_q.size(), 0);
            axi_read(32'h4, d, r, lat);
            check("rnd_status", d, ST_IDLE);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
